// File: rtl/ahb5_subordinate_arbiter.sv
// rtl/ahb5_subordinate_arbiter.sv - round-robin AHB5 manager arbiter for one subordinate port
//
// Purpose:
//   Lets NUM_MASTERS AHB5 managers share a single subordinate port. Drives the
//   address-phase mux select (addr_grant / HMASTER) and the data-phase select
//   (data_owner / data_valid). Fixed-length bursts are never split, locked
//   sequences keep the bus, and the bus parks on DEFAULT_MASTER when idle.
//
// Ports:
//   HCLK          bus clock, all state on the rising edge
//   HRESETn       asynchronous active-low reset
//   htrans_in     HTRANS per manager, [2i+1:2i] = manager i
//   hburst_in     HBURST per manager, [3i+2:3i] = manager i
//   hmastlock_in  HMASTLOCK per manager
//   HREADY        HREADYOUT of the subordinate; state only moves when high
//   addr_grant    one-hot address-phase grant
//   HMASTER       index of the address-phase owner
//   data_owner    index of the manager owning the current data phase
//   data_valid    current data phase carries a NONSEQ/SEQ transfer
//   HMASTLOCK     hmastlock_in of the address-phase owner
module ahb5_subordinate_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [2*NUM_MASTERS-1:0] htrans_in,
  input  logic [3*NUM_MASTERS-1:0] hburst_in,
  input  logic [NUM_MASTERS-1:0]   hmastlock_in,
  input  logic                     HREADY,
  output logic [NUM_MASTERS-1:0]   addr_grant,
  output logic [MW-1:0]            HMASTER,
  output logic [MW-1:0]            data_owner,
  output logic                     data_valid,
  output logic                     HMASTLOCK
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'b000;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {
    S_PARK  = 2'd0,
    S_BURST = 2'd1,
    S_UNDEF = 2'd2,
    S_LOCK  = 2'd3
  } state_t;

  state_t           fsm;
  logic [MW-1:0]    rr_ptr;
  logic [3:0]       beat_cnt;
  logic [3:0]       beat_term;

  logic [1:0]             owner_trans;
  logic [2:0]             owner_burst;
  logic                   owner_lock;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] arb_req;
  logic [MW-1:0]          arb_base;
  logic                   accept_ns;
  logic                   start_seq;
  logic                   arb_open;
  logic [3:0]             burst_term;
  logic                   win_found;
  logic [MW-1:0]          win_idx;
  int                     cand;

  // Fields of the current address-phase owner, plus the raw request vector.
  always_comb begin
    owner_trans = TR_IDLE;
    owner_burst = HB_SINGLE;
    owner_lock  = 1'b0;
    req         = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req[i] = (htrans_in[2*i +: 2] == TR_NONSEQ);
      if (HMASTER == MW'(i)) begin
        owner_trans = htrans_in[2*i +: 2];
        owner_burst = hburst_in[3*i +: 3];
        owner_lock  = hmastlock_in[i];
      end
    end
  end

  assign HMASTLOCK = owner_lock;

  always_comb begin
    burst_term = 4'd0;
    case (owner_burst)
      3'b010, 3'b011: burst_term = 4'd3;
      3'b100, 3'b101: burst_term = 4'd7;
      3'b110, 3'b111: burst_term = 4'd15;
      default:        burst_term = 4'd0;
    endcase
  end

  // A NONSEQ from the granted manager in PARK is the first address of a new
  // transfer. If it opens a multi-beat or locked sequence the grant stays put;
  // a plain SINGLE is finished after this address, so the bus is re-arbitrated
  // on the same edge with that manager's (already served) request masked out.
  // Elsewhere an owner NONSEQ that ends a sequence is a fresh request and
  // competes like any other.
  always_comb begin
    accept_ns = (fsm == S_PARK) && (owner_trans == TR_NONSEQ);
    start_seq = accept_ns && (owner_lock || (owner_burst != HB_SINGLE));
    arb_open  = 1'b0;
    case (fsm)
      S_PARK:  arb_open = !start_seq;
      S_BURST: arb_open = (owner_trans == TR_IDLE) || (owner_trans == TR_NONSEQ) ||
                          ((owner_trans == TR_SEQ) && ((beat_cnt + 4'd1) == beat_term));
      S_UNDEF: arb_open = (owner_trans == TR_IDLE) || (owner_trans == TR_NONSEQ);
      S_LOCK:  arb_open = !owner_lock;
      default: arb_open = 1'b1;
    endcase
    arb_base = accept_ns ? HMASTER : rr_ptr;
    arb_req  = accept_ns ? (req & ~addr_grant) : req;
  end

  // Round-robin search starting one past the base index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = MW'(DEFAULT_MASTER);
    cand      = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(arb_base) + k) % NUM_MASTERS;
      if (!win_found && arb_req[cand]) begin
        win_found = 1'b1;
        win_idx   = MW'(cand);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fsm        <= S_PARK;
      rr_ptr     <= MW'(DEFAULT_MASTER);
      beat_cnt   <= 4'd0;
      beat_term  <= 4'd0;
      HMASTER    <= MW'(DEFAULT_MASTER);
      addr_grant <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      data_owner <= MW'(DEFAULT_MASTER);
      data_valid <= 1'b0;
    end else if (HREADY) begin
      data_owner <= HMASTER;
      data_valid <= owner_trans[1];
      if (accept_ns) begin
        rr_ptr <= HMASTER;
      end
      if (arb_open) begin
        // win_idx already falls back to the park master when nobody requests.
        fsm        <= S_PARK;
        beat_cnt   <= 4'd0;
        HMASTER    <= win_idx;
        addr_grant <= NUM_MASTERS'(1) << win_idx;
      end else begin
        case (fsm)
          S_PARK: begin
            beat_cnt <= 4'd0;
            if (owner_lock) begin
              fsm <= S_LOCK;
            end else if (owner_burst == HB_INCR) begin
              fsm <= S_UNDEF;
            end else begin
              fsm       <= S_BURST;
              beat_term <= burst_term;
            end
          end
          S_BURST: begin
            // BUSY holds the count; only accepted SEQ beats advance it.
            if (owner_trans == TR_SEQ) begin
              beat_cnt <= beat_cnt + 4'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb5_subordinate_arbiter.sv
// tb/tb_ahb5_subordinate_arbiter.sv - table-driven bench for ahb5_subordinate_arbiter
module tb_ahb5_subordinate_arbiter;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [7:0]  htrans_in;
  logic [11:0] hburst_in;
  logic [3:0]  hmastlock_in;
  logic        HREADY;
  logic [3:0]  addr_grant;
  logic [1:0]  HMASTER;
  logic [1:0]  data_owner;
  logic        data_valid;
  logic        HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb5_subordinate_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .htrans_in    (htrans_in),
    .hburst_in    (hburst_in),
    .hmastlock_in (hmastlock_in),
    .HREADY       (HREADY),
    .addr_grant   (addr_grant),
    .HMASTER      (HMASTER),
    .data_owner   (data_owner),
    .data_valid   (data_valid),
    .HMASTLOCK    (HMASTLOCK)
  );

  typedef struct {
    int          test;
    logic [7:0]  ht;
    logic [11:0] hb;
    logic [3:0]  lk;
    logic        rdy;
    logic [1:0]  e_m;
    logic [1:0]  e_do;
    logic        e_dv;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [7:0] ht(input logic [1:0] t3, input logic [1:0] t2,
                                    input logic [1:0] t1, input logic [1:0] t0);
    return {t3, t2, t1, t0};
  endfunction

  task automatic add(input int t, input logic [7:0] h, input logic [11:0] b,
                     input logic [3:0] l, input logic r, input logic [1:0] em,
                     input logic [1:0] edo, input logic edv);
    vec_t v;
    v.test = t; v.ht = h; v.hb = b; v.lk = l; v.rdy = r;
    v.e_m = em; v.e_do = edo; v.e_dv = edv;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] e_m, input logic [1:0] e_do,
                       input logic e_dv, input logic e_lk);
    logic [3:0] e_g;
    e_g = 4'b0001 << e_m;
    n_vec++;
    if (addr_grant !== e_g || HMASTER !== e_m || data_owner !== e_do ||
        data_valid !== e_dv || HMASTLOCK !== e_lk) begin
      n_bad++;
      $display("FAIL %s: grant=%b want %b, HMASTER=%0d want %0d, data_owner=%0d want %0d, data_valid=%b want %b, HMASTLOCK=%b want %b",
               name, addr_grant, e_g, HMASTER, e_m, data_owner, e_do, data_valid, e_dv, HMASTLOCK, e_lk);
    end
  endtask

  task automatic drive(input logic [7:0] h, input logic [11:0] b, input logic [3:0] l, input logic r);
    htrans_in = h; hburst_in = b; hmastlock_in = l; HREADY = r;
  endtask

  initial begin
    // 1: idle after reset stays parked on manager 0
    for (int i = 0; i < 10; i++) add(1, 8'h00, 12'h000, 4'h0, 1'b1, 2'd0, 2'd0, 1'b0);

    // 2: managers 1..3 NONSEQ SINGLE together
    add(2, ht(NS, NS, NS, ID), 12'h000, 4'h0, 1'b1, 2'd1, 2'd0, 1'b0);
    add(2, ht(NS, NS, NS, ID), 12'h000, 4'h0, 1'b1, 2'd2, 2'd1, 1'b1);
    add(2, ht(NS, NS, ID, ID), 12'h000, 4'h0, 1'b1, 2'd3, 2'd2, 1'b1);
    add(2, ht(NS, ID, ID, ID), 12'h000, 4'h0, 1'b1, 2'd0, 2'd3, 1'b1);
    add(2, ht(ID, ID, ID, ID), 12'h000, 4'h0, 1'b1, 2'd0, 2'd0, 1'b0);

    // 3: manager 2 INCR8 while manager 1 requests
    add(3, ht(ID, NS, ID, ID), {3'b000, 3'b101, 6'b0}, 4'h0, 1'b1, 2'd2, 2'd0, 1'b0);
    add(3, ht(ID, NS, NS, ID), {3'b000, 3'b101, 6'b0}, 4'h0, 1'b1, 2'd2, 2'd2, 1'b1);
    for (int i = 0; i < 6; i++)
      add(3, ht(ID, SQ, NS, ID), {3'b000, 3'b101, 6'b0}, 4'h0, 1'b1, 2'd2, 2'd2, 1'b1);
    add(3, ht(ID, SQ, NS, ID), {3'b000, 3'b101, 6'b0}, 4'h0, 1'b1, 2'd1, 2'd2, 1'b1);
    add(3, ht(ID, ID, NS, ID), 12'h000, 4'h0, 1'b1, 2'd0, 2'd1, 1'b1);
    add(3, ht(ID, ID, ID, ID), 12'h000, 4'h0, 1'b1, 2'd0, 2'd0, 1'b0);

    // 4: manager 3 INCR4 with one BUSY and two wait states
    add(4, ht(NS, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd3, 2'd0, 1'b0);
    add(4, ht(NS, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd3, 2'd3, 1'b1);
    add(4, ht(SQ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd3, 2'd3, 1'b1);
    add(4, ht(BZ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd3, 2'd3, 1'b0);
    add(4, ht(SQ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd3, 2'd3, 1'b1);
    add(4, ht(SQ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b0, 2'd3, 2'd3, 1'b1);
    add(4, ht(SQ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b0, 2'd3, 2'd3, 1'b1);
    add(4, ht(SQ, ID, ID, ID), {3'b011, 9'b0}, 4'h0, 1'b1, 2'd0, 2'd3, 1'b1);
    add(4, ht(ID, ID, ID, ID), 12'h000, 4'h0, 1'b1, 2'd0, 2'd0, 1'b0);

    // 5: manager 1 locked SINGLE, IDLE, SINGLE while manager 0 requests
    add(5, ht(ID, ID, NS, ID), 12'h000, 4'b0010, 1'b1, 2'd1, 2'd0, 1'b0);
    add(5, ht(ID, ID, NS, NS), 12'h000, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b1);
    add(5, ht(ID, ID, ID, NS), 12'h000, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b0);
    add(5, ht(ID, ID, NS, NS), 12'h000, 4'b0010, 1'b1, 2'd1, 2'd1, 1'b1);
    add(5, ht(ID, ID, ID, NS), 12'h000, 4'b0000, 1'b1, 2'd0, 2'd1, 1'b0);
    add(5, ht(ID, ID, ID, NS), 12'h000, 4'b0000, 1'b1, 2'd0, 2'd0, 1'b1);
    add(5, ht(ID, ID, ID, ID), 12'h000, 4'b0000, 1'b1, 2'd0, 2'd0, 1'b0);

    HRESETn = 1'b0;
    drive(8'h00, 12'h000, 4'h0, 1'b1);
    repeat (2) @(posedge HCLK);
    #1;
    check("reset", 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ht, vecs[i].hb, vecs[i].lk, vecs[i].rdy);
      @(posedge HCLK);
      #1;
      check($sformatf("t%0d_v%0d", vecs[i].test, i), vecs[i].e_m, vecs[i].e_do,
            vecs[i].e_dv, vecs[i].lk[vecs[i].e_m]);
    end

    // 6: reset asserted during beat 3 of an INCR16 from manager 2
    drive(ht(ID, NS, ID, ID), {3'b000, 3'b111, 6'b0}, 4'h0, 1'b1);
    @(posedge HCLK); #1;
    check("t6_grant", 2'd2, 2'd0, 1'b0, 1'b0);
    @(posedge HCLK); #1;
    check("t6_beat1", 2'd2, 2'd2, 1'b1, 1'b0);
    drive(ht(ID, SQ, ID, ID), {3'b000, 3'b111, 6'b0}, 4'h0, 1'b1);
    @(posedge HCLK); #1;
    check("t6_beat2", 2'd2, 2'd2, 1'b1, 1'b0);
    #2;
    HRESETn = 1'b0;
    #1;
    check("t6_reset_async", 2'd0, 2'd0, 1'b0, 1'b0);
    @(posedge HCLK); #1;
    check("t6_reset_held", 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    // Pointer back at 0: manager 1 beats manager 3.
    drive(ht(NS, ID, NS, ID), 12'h000, 4'h0, 1'b1);
    @(posedge HCLK); #1;
    check("t6_after_reset", 2'd1, 2'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
